ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of ALU result, store data and PC+4.
REQ-002 SHALL have parameter REG_AW, default 5, destination-register index width.
REQ-003 SHALL have parameter CNT_W, default 16, backpressure counter width.
REQ-004 SHALL have ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset; synchronous, active-low.
- flush  input  1  discard all held entries.
- in_valid  input  1  EX stage offers an entry.
- in_ready  output  1  stage accepts an entry this cycle.
- ALUResultE  input  XLEN  ALU result.
- WriteDataE  input  XLEN  store data.
- RdE  input  REG_AW  destination register.
- PCPlus4E  input  XLEN  return address.
- RegWriteE  input  1  register-write enable.
- MemWriteE  input  1  memory-write enable.
- ResultSrcE  input  2  writeback select.
- out_valid  output  1  MEM stage entry valid.
- out_ready  input  1  MEM stage accepts.
- ALUResultM, WriteDataM, PCPlus4M  output  XLEN  registered payload.
- RdM  output  REG_AW  registered destination.
- RegWriteM, MemWriteM  output  1  registered control, qualified.
- ResultSrcM  output  2  registered writeback select.
- stall_cnt  output  CNT_W  backpressure cycle count.

Function
REQ-005 SHALL transfer an entry in when in_valid && in_ready, and out when out_valid && out_ready, both on the rising clk edge.
REQ-006 SHALL give one-cycle latency: an accepted entry appears on the M outputs the next cycle with out_valid=1.
REQ-007 SHALL hold the M outputs and out_valid stable while out_valid && !out_ready.
REQ-008 SHALL force RegWriteM=0 when RdM==0, so no x0 write propagates.
REQ-009 SHALL force RegWriteM=0 and MemWriteM=0 whenever out_valid=0.
REQ-010 SHALL, on flush, clear out_valid and every internal valid at the next edge; payload registers may keep stale values.
REQ-011 SHALL give flush priority over a simultaneous in-transfer; that entry is dropped.
REQ-012 SHALL increment stall_cnt each cycle with out_valid && !out_ready, saturating at all-ones (no wrap).
REQ-013 SHALL pass payload bit-exact, with no width conversion.

Reset
REQ-014 SHALL, while reset=0 at a clk edge, clear all M payload outputs, out_valid, control outputs, internal valids and stall_cnt to 0.
REQ-015 SHALL drive in_ready=0 while reset is asserted.
REQ-016 SHALL drop any partially held entry when reset is asserted mid-operation, with no later replay.

Configuration
REQ-017 SHALL honour the macro EX_MEM_SKID_EN.
REQ-018 With EX_MEM_SKID_EN defined:
- two-entry skid buffer; in_ready is driven directly from a register (no combinational path from out_ready).
- full throughput of one entry per cycle; a second entry is accepted during the first backpressure cycle.
- in_ready=0 only when both entries are full.
REQ-019 Without EX_MEM_SKID_EN:
- single entry; in_ready = out_ready || !out_valid (combinational).
- behaviour is identical to REQ-005..REQ-016 in every other respect.

Structure
REQ-020 SHALL take the following from shared package riscv_pipe_pkg:
- XLEN/REG_AW defaults.
- ResultSrc encoding constants (RES_ALU=0, RES_MEM=1, RES_PC4=2).
- a packed ex_mem_payload_t typedef.
REQ-021 SHALL implement the skid storage in sub-module pipe_skid_buf, parametrised on payload width, instantiated only when EX_MEM_SKID_EN is defined.

Verification
REQ-022 Stimulus: reset=0 for 2 cycles, then release. Required: all outputs 0; in_ready=1 on the first cycle after release.
REQ-023 Stimulus: single transfer ALUResultE=0x0000_1234, RdE=5, RegWriteE=1, out_ready=1. Required: next cycle out_valid=1, ALUResultM=0x0000_1234, RdM=5, RegWriteM=1.
REQ-024 Stimulus: RdE=0, RegWriteE=1, MemWriteE=0. Required: RegWriteM=0, out_valid=1.
REQ-025 Stimulus: with skid, stream A,B,C with out_ready=0 from cycle 1 for 3 cycles. Required:
- A held on the outputs; B accepted; in_ready=0 after B; C not accepted.
- stall_cnt=3.
- after out_ready=1, A then B are delivered in order.
REQ-026 Stimulus: flush asserted together with in_valid=1 while one entry is held. Required: next cycle out_valid=0, and the new entry is never output.
REQ-027 Stimulus: CNT_W=4 with 20 stall cycles. Required: stall_cnt=15 (saturated).

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V pipeline register stages:
// default widths, writeback-select encoding and the EX/MEM payload layout.
package riscv_pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    // ResultSrc encoding used by the writeback mux
    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    // EX/MEM payload at the default widths; stages built with other widths
    // keep this field order so the packed layout stays compatible.
    typedef struct packed {
        logic [XLEN_DEF-1:0]   alu_result;
        logic [XLEN_DEF-1:0]   write_data;
        logic [XLEN_DEF-1:0]   pc_plus4;
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_write;
        logic                  mem_write;
        logic [1:0]            result_src;
    } ex_mem_payload_t;

    // Packed payload width for a given datapath / register-index width
    function automatic int payload_w(input int xlen, input int reg_aw);
        return 3 * xlen + reg_aw + 4;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer for a valid/ready pipeline register.
// The output entry is the visible one; the skid entry catches the word that
// arrives during the first backpressure cycle. in_ready depends only on the
// skid register (and reset), never on out_ready.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         pop;

    assign in_ready = reset && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Output and skid registers: refill the output from skid first, then from
    // the input; park an input word in skid when the output is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, write-enable
// qualification and a saturating backpressure counter.
// Build option: define EX_MEM_SKID_EN for a two-entry skid buffer with a
// registered in_ready; otherwise a single entry with combinational in_ready.
module ex_mem_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   WriteDataE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic [1:0]        ResultSrcE,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Same field order as ex_mem_payload_t, sized by this instance's parameters
    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
    } stage_payload_t;

    stage_payload_t pay_in;
    stage_payload_t pay_q;
    logic           valid_q;

    assign pay_in = '{alu_result: ALUResultE, write_data: WriteDataE,
                      pc_plus4: PCPlus4E, rd: RdE, reg_write: RegWriteE,
                      mem_write: MemWriteE, result_src: ResultSrcE};

`ifdef EX_MEM_SKID_EN
    localparam int PW = payload_w(XLEN, REG_AW);

    pipe_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (valid_q),
        .out_ready (out_ready),
        .out_data  (pay_q)
    );
`else
    assign in_ready = reset && (out_ready || !valid_q);

    // Single-entry register: flush beats a simultaneous load, a load replaces
    // a departing entry, otherwise the entry drains when MEM accepts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            pay_q   <= pay_in;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid  = valid_q;
    assign ALUResultM = pay_q.alu_result;
    assign WriteDataM = pay_q.write_data;
    assign PCPlus4M   = pay_q.pc_plus4;
    assign RdM        = pay_q.rd;
    assign ResultSrcM = pay_q.result_src;
    // Writes only leave with a valid entry; x0 is never written
    assign RegWriteM  = valid_q && pay_q.reg_write && (pay_q.rd != '0);
    assign MemWriteM  = valid_q && pay_q.mem_write;

    // Count backpressure cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_ex_mem_stage;
    import riscv_pipe_pkg::*;

`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [15:0] stall_cnt;

    // second instance with a narrow counter for the saturation check
    logic        in_valid2, out_ready2, flush2;
    logic        in_ready2, out_valid2;
    logic [31:0] ALUResultM2, WriteDataM2, PCPlus4M2;
    logic [4:0]  RdM2;
    logic        RegWriteM2, MemWriteM2;
    logic [1:0]  ResultSrcM2;
    logic [3:0]  stall_cnt2;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
        .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .stall_cnt(stall_cnt)
    );

    ex_mem_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
        .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .ALUResultM(ALUResultM2), .WriteDataM(WriteDataM2), .PCPlus4M(PCPlus4M2),
        .RdM(RdM2), .RegWriteM(RegWriteM2), .MemWriteM(MemWriteM2),
        .ResultSrcM(ResultSrcM2), .stall_cnt(stall_cnt2)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        regw, memw;
        logic [1:0]  rsrc;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cnt    = 0;
    bit          pay_zero = 1'b1;

    function automatic ent_t cur_entry();
        ent_t e;
        e.alu  = ALUResultE; e.wd = WriteDataE; e.pc4 = PCPlus4E;
        e.rd   = RdE; e.regw = RegWriteE; e.memw = MemWriteE; e.rsrc = ResultSrcE;
        return e;
    endfunction

    function automatic bit m_in_ready();
        if (!reset) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return out_ready || (q.size() == 0);
    endfunction

    always @(posedge clk) begin
        bit push, pop;
        if (!reset) begin
            q.delete();
            m_cnt    = 0;
            pay_zero = 1'b1;
        end else begin
            if (q.size() > 0 && !out_ready && m_cnt < 65535) m_cnt++;
            push = in_valid && m_in_ready();
            pop  = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back(cur_entry());
                    pay_zero = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // compare process: DUT against model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {127'd0, in_ready}, {127'd0, m_in_ready()});
            chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
            chk("stall_cnt", {112'd0, stall_cnt}, 128'(m_cnt));
            if (q.size() != 0) begin
                chk("payload", {23'd0, ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM},
                    {23'd0, q[0].alu, q[0].wd, q[0].pc4, q[0].rd, q[0].rsrc});
                chk("RegWriteM", {127'd0, RegWriteM}, {127'd0, q[0].regw && (q[0].rd != 5'd0)});
                chk("MemWriteM", {127'd0, MemWriteM}, {127'd0, q[0].memw});
            end else begin
                chk("RegWriteM_idle", {127'd0, RegWriteM}, 128'd0);
                chk("MemWriteM_idle", {127'd0, MemWriteM}, 128'd0);
                if (pay_zero)
                    chk("payload_rst", {23'd0, ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM}, 128'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                          input logic rw, input logic mw);
        in_valid   = v;
        ALUResultE = alu;
        WriteDataE = alu ^ 32'hFFFF_0000;
        PCPlus4E   = alu + 32'd4;
        RdE        = rd;
        RegWriteE  = rw;
        MemWriteE  = mw;
        ResultSrcE = RES_ALU;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; flush2 = 1'b0;
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

        // reset held for two edges, then released
        cyc(); cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_alu", {96'd0, ALUResultM}, 128'd0);
        chk("rst_stall", {112'd0, stall_cnt}, 128'd0);
        cyc();

        // single transfer
        out_ready = 1'b1;
        set_in(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("xfer_valid", {127'd0, out_valid}, 128'd1);
        chk("xfer_alu", {96'd0, ALUResultM}, 128'h1234);
        chk("xfer_rd", {123'd0, RdM}, 128'd5);
        chk("xfer_regw", {127'd0, RegWriteM}, 128'd1);
        cyc();

        // write to x0 is suppressed
        set_in(1'b1, 32'h0000_0077, 5'd0, 1'b1, 1'b0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("x0_valid", {127'd0, out_valid}, 128'd1);
        chk("x0_regw", {127'd0, RegWriteM}, 128'd0);
        cyc();

        // stream A,B,C under three cycles of backpressure
        set_in(1'b1, 32'h0000_000A, 5'd1, 1'b1, 1'b0);
        cyc();
        set_in(1'b1, 32'h0000_000B, 5'd2, 1'b1, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_b", {127'd0, in_ready}, {127'd0, CAP == 2});
        cyc();
        set_in(1'b1, 32'h0000_000C, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_ready_c", {127'd0, in_ready}, 128'd0);
        chk("bp_hold_a", {96'd0, ALUResultM}, 128'hA);
        cyc();
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_stall3", {112'd0, stall_cnt}, 128'd3);
        chk("bp_out_a", {96'd0, ALUResultM}, 128'hA);
        cyc();
        @(negedge clk);
        if (CAP == 2) chk("bp_out_b", {96'd0, ALUResultM}, 128'hB);
        else          chk("bp_drained", {127'd0, out_valid}, 128'd0);
        cyc();
        @(negedge clk);
        chk("bp_empty", {127'd0, out_valid}, 128'd0);
        cyc();

        // flush with a simultaneous offer while one entry is held
        out_ready = 1'b0;
        set_in(1'b1, 32'h0000_5A5A, 5'd7, 1'b1, 1'b1);
        cyc();
        flush = 1'b1;
        set_in(1'b1, 32'h0000_DEAD, 5'd8, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_held", {127'd0, out_valid}, 128'd1);
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_cleared", {127'd0, out_valid}, 128'd0);
        chk("fl_memw", {127'd0, MemWriteM}, 128'd0);
        cyc();
        repeat (3) cyc();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int thr;
            thr       = (i / 100) % 4;
            reset     = ($urandom_range(0, 63) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) <= thr);
            set_in($urandom_range(0, 1), $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom_range(0, 1), $urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 2));
            cyc();
        end

        // saturating counter on the CNT_W=4 instance
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        reset = 1'b1;
        in_valid2  = 1'b1;
        out_ready2 = 1'b0;
        cyc();
        in_valid2 = 1'b0;
        repeat (14) cyc();
        @(negedge clk);
        chk("sat_14", {124'd0, stall_cnt2}, 128'd14);
        cyc();
        repeat (5) cyc();
        @(negedge clk);
        chk("sat_15", {124'd0, stall_cnt2}, 128'd15);
        chk("sat_valid", {127'd0, out_valid2}, 128'd1);
        cyc();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
